// File: rtl/fpmult_mant_norm.sv
`default_nettype none
// ============================================================================
// Module   : fpmult_mant_norm
// Brief    : FP32 multiplier front end. Unpacks two IEEE-754 single operands,
//            multiplies the 24-bit significands RADIX_BITS bits per cycle and
//            normalizes the 48-bit product into the fraction / exponent /
//            round-decision form consumed by the rounding stage.
// Revision : 1.0 - initial release
// ============================================================================
module fpmult_mant_norm #(
    parameter int RADIX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] NormM,
    output logic [8:0]  NormE,
    output logic        Sp,
    output logic        GRS,
    output logic [4:0]  InputExc
);

    localparam int         c_ITER = 24 / RADIX_BITS;
    localparam logic [4:0] c_LAST = 5'(c_ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [47:0] r_maShift;   // Ma pre-shifted to the weight of the current digit
    logic [23:0] r_mbShift;   // Mb with consumed digits shifted out
    logic [8:0]  r_esum;
    logic [47:0] r_acc;
    logic [4:0]  r_cnt;
    logic [22:0] r_normM;
    logic [8:0]  r_normE;
    logic        r_sp;
    logic        r_grs;
    logic [4:0]  r_inputExc;

    // ------------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------------
    logic        w_aExpMax, w_bExpMax, w_aExpZero, w_bExpZero;
    logic        w_aFracZero, w_bFracZero;
    logic [23:0] w_ma, w_mb;
    logic [8:0]  w_esum;
    logic [4:0]  w_exc;

    assign w_aExpMax   = (a[30:23] == 8'hFF);
    assign w_bExpMax   = (b[30:23] == 8'hFF);
    assign w_aExpZero  = (a[30:23] == 8'h00);
    assign w_bExpZero  = (b[30:23] == 8'h00);
    assign w_aFracZero = (a[22:0] == 23'd0);
    assign w_bFracZero = (b[22:0] == 23'd0);

    // Hidden bit is present only for non-zero exponents (denormals keep 0).
    assign w_ma   = {~w_aExpZero, a[22:0]};
    assign w_mb   = {~w_bExpZero, b[22:0]};
    assign w_esum = {1'b0, a[30:23]} + {1'b0, b[30:23]};

    assign w_exc[4] = (w_aExpMax & ~w_aFracZero) | (w_bExpMax & ~w_bFracZero);
    assign w_exc[3] = w_aExpMax & w_aFracZero;
    assign w_exc[2] = w_bExpMax & w_bFracZero;
    assign w_exc[1] = w_aExpZero & w_aFracZero;
    assign w_exc[0] = w_bExpZero & w_bFracZero;

    // ------------------------------------------------------------------------
    // Iterative multiply: one RADIX_BITS digit of Mb per cycle, LSB first.
    // Ma is kept pre-shifted, so each partial product lands at its weight
    // without a variable shifter. The full product always fits in 48 bits,
    // so no partial sum can overflow the accumulator.
    // ------------------------------------------------------------------------
    logic [RADIX_BITS-1:0] w_digit;
    logic [47:0]           w_pp;
    logic [47:0]           w_accNext;

    assign w_digit   = r_mbShift[RADIX_BITS-1:0];
    assign w_pp      = r_maShift * {{(48-RADIX_BITS){1'b0}}, w_digit};
    assign w_accNext = r_acc + w_pp;

    // ------------------------------------------------------------------------
    // Normalization of the finished product held in r_acc
    // ------------------------------------------------------------------------
    logic        w_top;
    logic [22:0] w_normM;
    logic        w_g, w_r, w_s;
    logic [8:0]  w_normE;
    logic        w_grs;

    assign w_top   = r_acc[47];
    assign w_normM = w_top ? r_acc[46:24] : r_acc[45:23];
    assign w_g     = w_top ? r_acc[23]    : r_acc[22];
    assign w_r     = w_top ? r_acc[22]    : r_acc[21];
    assign w_s     = w_top ? (|r_acc[21:0]) : (|r_acc[20:0]);
    assign w_normE = r_esum + {8'd0, w_top};
    // Round to nearest, ties to even.
    assign w_grs   = w_g & (w_normM[0] | w_r | w_s);

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_maShift  <= 48'd0;
            r_mbShift  <= 24'd0;
            r_esum     <= 9'd0;
            r_acc      <= 48'd0;
            r_cnt      <= 5'd0;
            r_normM    <= 23'd0;
            r_normE    <= 9'd0;
            r_sp       <= 1'b0;
            r_grs      <= 1'b0;
            r_inputExc <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_maShift  <= {24'd0, w_ma};
                        r_mbShift  <= w_mb;
                        r_esum     <= w_esum;
                        r_sp       <= a[31] ^ b[31];
                        r_inputExc <= w_exc;
                        r_acc      <= 48'd0;
                        r_cnt      <= 5'd0;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc     <= w_accNext;
                    r_maShift <= r_maShift << RADIX_BITS;
                    r_mbShift <= r_mbShift >> RADIX_BITS;
                    r_cnt     <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_normM <= w_normM;
                    r_normE <= w_normE;
                    r_grs   <= w_grs;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign out_valid = (r_state == S_DONE);
    assign NormM     = r_normM;
    assign NormE     = r_normE;
    assign Sp        = r_sp;
    assign GRS       = r_grs;
    assign InputExc  = r_inputExc;

endmodule
`default_nettype wire

// File: tb/tb_fpmult_mant_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpmult_mant_norm
// Brief    : Scoreboard bench for fpmult_mant_norm at RADIX_BITS 4, 1 and 24.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpmult_mant_norm;

    typedef struct packed {
        logic [22:0] m;
        logic [8:0]  e;
        logic        sp;
        logic        grs;
        logic [4:0]  exc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        inValid  [3];
    logic        outReady [3];
    logic        inReady  [3];
    logic        outValid [3];
    logic [22:0] normM    [3];
    logic [8:0]  normE    [3];
    logic        sp       [3];
    logic        grs      [3];
    logic [4:0]  inputExc [3];

    exp_t sb[$];
    int   errCnt = 0;
    int   chkCnt = 0;

    fpmult_mant_norm #(.RADIX_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(a), .b(b), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .NormM(normM[0]), .NormE(normE[0]), .Sp(sp[0]), .GRS(grs[0]),
        .InputExc(inputExc[0])
    );
    fpmult_mant_norm #(.RADIX_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(a), .b(b), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .NormM(normM[1]), .NormE(normE[1]), .Sp(sp[1]), .GRS(grs[1]),
        .InputExc(inputExc[1])
    );
    fpmult_mant_norm #(.RADIX_BITS(24)) u_dut24 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a(a), .b(b), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .NormM(normM[2]), .NormE(normE[2]), .Sp(sp[2]), .GRS(grs[2]),
        .InputExc(inputExc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the unpack / multiply / normalize path
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        logic [47:0] p;
        logic [23:0] mx, my;
        logic [8:0]  es;
        logic        g, rr, s;
        mx = {(x[30:23] != 8'd0), x[22:0]};
        my = {(y[30:23] != 8'd0), y[22:0]};
        p  = {24'd0, mx} * {24'd0, my};
        es = {1'b0, x[30:23]} + {1'b0, y[30:23]};
        if (p[47]) begin
            r.m = p[46:24]; g = p[23]; rr = p[22]; s = |p[21:0]; r.e = es + 9'd1;
        end else begin
            r.m = p[45:23]; g = p[22]; rr = p[21]; s = |p[20:0]; r.e = es;
        end
        r.grs    = g & (r.m[0] | rr | s);
        r.sp     = x[31] ^ y[31];
        r.exc[4] = (x[30:23] == 8'hFF && x[22:0] != 0) || (y[30:23] == 8'hFF && y[22:0] != 0);
        r.exc[3] = (x[30:23] == 8'hFF && x[22:0] == 0);
        r.exc[2] = (y[30:23] == 8'hFF && y[22:0] == 0);
        r.exc[1] = (x[30:0] == 31'd0);
        r.exc[0] = (y[30:0] == 31'd0);
        return r;
    endfunction

    task automatic checkOut(input int idx, input exp_t e, input string tag);
        check({tag, ".NormM"},    normM[idx],    e.m);
        check({tag, ".NormE"},    normE[idx],    e.e);
        check({tag, ".Sp"},       sp[idx],       e.sp);
        check({tag, ".GRS"},      grs[idx],      e.grs);
        check({tag, ".InputExc"}, inputExc[idx], e.exc);
    endtask

    // Drive one operand pair, wait for the result and compare against the scoreboard.
    task automatic doTxn(input int idx, input logic [31:0] x, input logic [31:0] y,
                         input int lat, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!inReady[idx] && n < 50) begin step(); n++; end
        check({tag, ".in_ready"}, inReady[idx], 1'b1);
        a = x; b = y; inValid[idx] = 1'b1;
        sb.push_back(model(x, y));
        step();
        inValid[idx] = 1'b0;
        a = $urandom; b = $urandom;
        n = 0;
        while (!outValid[idx] && n < 100) begin step(); n++; end
        check({tag, ".latency"}, n, lat);
        e = sb.pop_front();
        if (outValid[idx]) checkOut(idx, e, tag);
        step();
        check({tag, ".out_valid_drop"}, outValid[idx], 1'b0);
        check({tag, ".in_ready_back"}, inReady[idx], 1'b1);
    endtask

    initial begin
        int   n;
        int   seen;
        exp_t e;
        rst = 1'b1;
        a = '0; b = '0;
        for (int i = 0; i < 3; i++) begin
            inValid[i] = 1'b0; outReady[i] = 1'b1;
        end
        step(); step();
        check("rst.in_ready",  inReady[0],  1'b0);
        check("rst.out_valid", outValid[0], 1'b0);
        check("rst.outs", {normM[0], normE[0], sp[0], grs[0], inputExc[0]}, 64'd0);
        rst = 1'b0;
        #1;
        check("idle.in_ready", inReady[0], 1'b1);

        // Directed cases
        doTxn(0, 32'h3F800000, 32'h3F800000, 7, "one_x_one");
        doTxn(0, 32'h3FC00000, 32'h3FC00000, 7, "1p5_sq");
        doTxn(0, 32'hBF800001, 32'h3FC00000, 7, "rne_up");
        doTxn(0, 32'h7F800000, 32'h00000000, 7, "inf_zero");
        doTxn(0, 32'h7FC00000, 32'h3F800000, 7, "nan");
        doTxn(0, 32'h00400000, 32'h7F7FFFFF, 7, "denorm");
        doTxn(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 7, "max_exp");
        for (int i = 0; i < 6; i++) doTxn(0, $urandom, $urandom, 7, "random");

        // Backpressure: result held, pulsing in_valid ignored
        outReady[0] = 1'b0;
        a = 32'h40400000; b = 32'hC0A00000; inValid[0] = 1'b1;
        sb.push_back(model(32'h40400000, 32'hC0A00000));
        step();
        inValid[0] = 1'b0;
        n = 0;
        while (!outValid[0] && n < 100) begin step(); n++; end
        check("bp.latency", n, 7);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            inValid[0] = i[0];
            a = $urandom; b = $urandom;
            step();
            check("bp.out_valid", outValid[0], 1'b1);
            check("bp.in_ready",  inReady[0],  1'b0);
            checkOut(0, e, "bp");
        end
        inValid[0] = 1'b0;
        outReady[0] = 1'b1;
        step();
        check("bp.release_valid", outValid[0], 1'b0);
        check("bp.release_ready", inReady[0],  1'b1);
        doTxn(0, 32'h3FC00000, 32'h40000000, 7, "bp.second");

        // Reset during MUL discards the operation
        a = 32'h3FC00000; b = 32'h3FC00000; inValid[0] = 1'b1;
        step();
        inValid[0] = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        check("mrst.out_valid", outValid[0], 1'b0);
        check("mrst.in_ready",  inReady[0],  1'b0);
        step();
        rst = 1'b0;
        #1;
        check("mrst.in_ready_after", inReady[0], 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (outValid[0]) seen++;
        end
        check("mrst.no_result", seen, 0);
        doTxn(0, 32'h3FC00000, 32'h3FC00000, 7, "mrst.rerun");

        // Other radices
        doTxn(1, 32'h3FC00000, 32'h3FC00000, 25, "r1.1p5_sq");
        doTxn(2, 32'h3FC00000, 32'h3FC00000, 2,  "r24.1p5_sq");
        doTxn(1, 32'hBF800001, 32'h3FC00000, 25, "r1.rne_up");
        doTxn(2, 32'h12345678, 32'h9ABCDEF1, 2,  "r24.mixed");

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
`default_nettype wire
